hilo_div_ctrl: RTL and testbench

- Sequences the multi-cycle divider for DIV/DIVU in the EX stage and owns the architectural HI/LO register pair.
- While a divide runs, it stalls the pipeline. When the divider reports done, it commits the divider result; otherwise it commits single-cycle ALU HI/LO writes (MULT/MTHI/MTLO).
- Handles flush (exception/eret) by cancelling an in-flight divide without touching HI/LO.

---
 rtl/hilo_div_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
//   EX-stage sequencer for the multi-cycle DIV/DIVU divider and owner of the
//   architectural HI/LO register pair.
//   - IDLE: accepts single-cycle ALU HI/LO writes (MULT/MTHI/MTLO) or launches
//     a divide (operands and signedness latched, div_start pulsed next cycle).
//   - BUSY: stalls IF..EX until div_done, a flush, or the watchdog limit.
//   - WB:   releases the stall for one cycle so the DIV retires; HI/LO already
//     hold the quotient/remainder.
//   Optional feature macro: DIV_ZERO_BYPASS_EN
//     When defined, a divide by zero never reaches the divider; HI takes the
//     dividend and LO takes all-ones directly from IDLE.
//   All outputs are registered except stall_req.

module hilo_div_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_DIV_CYCLES = 40
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_div_req,
  input  logic              ex_div_signed,
  input  logic [DATA_W-1:0] ex_src_a,
  input  logic [DATA_W-1:0] ex_src_b,
  input  logic [1:0]        ex_hilo_we,
  input  logic [DATA_W-1:0] ex_alu_hi,
  input  logic [DATA_W-1:0] ex_alu_lo,
  input  logic              flush,
  output logic              div_start,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_op_a,
  output logic [DATA_W-1:0] div_op_b,
  output logic              div_cancel,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

`ifdef DIV_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] hi_q,      hi_d;
  logic [DATA_W-1:0] lo_q,      lo_d;
  logic [DATA_W-1:0] op_a_q,    op_a_d;
  logic [DATA_W-1:0] op_b_q,    op_b_d;
  logic              signed_q,  signed_d;
  logic              start_q,   start_d;
  logic              cancel_q,  cancel_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  // Saturating increment of the BUSY-cycle counter.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != CNT_SAT) begin
      cnt_inc = cnt_q + 1'b1;
    end
  end

  // Next-state, HI/LO commit, launch/cancel pulses and the stall request.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    signed_d  = signed_q;
    start_d   = 1'b0;
    cancel_d  = 1'b0;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    stall_req = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_div_req && !flush) begin
          // Stall already in the request cycle.
          stall_req = 1'b1;
          if (ZERO_BYPASS && (ex_src_b == '0)) begin
            state_d = WB;
            hi_d    = ex_src_a;
            lo_d    = '1;
          end else begin
            state_d  = BUSY;
            op_a_d   = ex_src_a;
            op_b_d   = ex_src_b;
            signed_d = ex_div_signed;
            start_d  = 1'b1;
            cnt_d    = '0;
          end
        end else if (!flush && !ex_div_req) begin
          if (ex_hilo_we[1]) hi_d = ex_alu_hi;
          if (ex_hilo_we[0]) lo_d = ex_alu_lo;
        end
      end

      BUSY: begin
        // Priority: flush, then divider result, then watchdog.
        if (flush) begin
          cancel_d = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_req = 1'b1;
          cnt_d     = cnt_inc;
          if (div_done) begin
            state_d = WB;
            hi_d    = div_hi;
            lo_d    = div_lo;
          end else if (cnt_inc == CNT_LIMIT) begin
            timeout_d = 1'b1;
            cancel_d  = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      WB: begin
        // ex_div_req still refers to the retiring DIV here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      signed_q  <= 1'b0;
      start_q   <= 1'b0;
      cancel_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      signed_q  <= signed_d;
      start_q   <= start_d;
      cancel_q  <= cancel_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign div_start   = start_q;
  assign div_signed  = signed_q;
  assign div_op_a    = op_a_q;
  assign div_op_b    = op_b_q;
  assign div_cancel  = cancel_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_timeout = timeout_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: plays the role of both the EX stage and the
// divider. Expected HI/LO come from plain integer division on the operands
// the bench itself issued, plus the ALU write-enable rules.
// Honours DIV_ZERO_BYPASS_EN the same way as the design.

module tb_hilo_div_ctrl;

  localparam int unsigned W    = 32;
  localparam int unsigned MAXC = 40;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_div_req, ex_div_signed, flush, div_done;
  logic [W-1:0] ex_src_a, ex_src_b, ex_alu_hi, ex_alu_lo, div_hi, div_lo;
  logic [1:0]   ex_hilo_we;
  logic         div_start, div_signed, div_cancel, stall_req, div_timeout;
  logic [W-1:0] div_op_a, div_op_b, hi_out, lo_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [W-1:0] exp_hi, exp_lo;

  hilo_div_ctrl #(.DATA_W(W), .MAX_DIV_CYCLES(MAXC)) dut (
    .clk(clk), .resetn(resetn),
    .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_hilo_we(ex_hilo_we), .ex_alu_hi(ex_alu_hi), .ex_alu_lo(ex_alu_lo),
    .flush(flush),
    .div_start(div_start), .div_signed(div_signed),
    .div_op_a(div_op_a), .div_op_b(div_op_b), .div_cancel(div_cancel),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .stall_req(stall_req), .hi_out(hi_out), .lo_out(lo_out),
    .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_div_req    = 1'b0;
    ex_div_signed = 1'b0;
    ex_src_a      = '0;
    ex_src_b      = '0;
    ex_hilo_we    = 2'b00;
    ex_alu_hi     = '0;
    ex_alu_lo     = '0;
    flush         = 1'b0;
    div_done      = 1'b0;
    div_hi        = '0;
    div_lo        = '0;
  endtask

  // MIPS-style quotient/remainder (truncating); by zero: q=all ones, r=a.
  function automatic void div_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Drives one divide from its request cycle. lat: BUSY cycle carrying
  // div_done (0 = never). flush_at: BUSY cycle carrying flush (0 = none).
  // Done path returns in the cycle after WB with ex_div_req still high.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int unsigned lat,
                         input int unsigned flush_at);
    logic [W-1:0] q, r;
    int unsigned  last;
    div_ref(a, b, sgn, q, r);
    last = (lat == 0) ? MAXC : lat;
    ex_div_req    = 1'b1;
    ex_src_a      = a;
    ex_src_b      = b;
    ex_div_signed = sgn;
    ex_hilo_we    = 2'($urandom);
    ex_alu_hi     = $urandom;
    ex_alu_lo     = $urandom;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL req_stall: stall_req=%b want 1", stall_req);
    end
    tick();
    for (int unsigned k = 1; k <= last; k++) begin
      checks++;
      if (div_start !== (k == 1)) begin
        errors++; $display("FAIL start_pulse k=%0d: div_start=%b want %b", k, div_start, (k == 1));
      end
      if (k == 1) begin
        checks++;
        if (div_signed !== sgn || div_op_a !== a || div_op_b !== b) begin
          errors++;
          $display("FAIL operands: sgn=%b a=%h b=%h want %b %h %h", div_signed, div_op_a, div_op_b, sgn, a, b);
        end
      end
      if (k == flush_at) begin
        flush = 1'b1;
        if (k == lat) begin
          div_done = 1'b1;
          div_hi   = ~r;
          div_lo   = ~q;
        end
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
          errors++; $display("FAIL flush_stall: stall_req=%b want 0", stall_req);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (div_cancel !== 1'b1 || stall_req !== 1'b0 || hi_out !== exp_hi || lo_out !== exp_lo) begin
          errors++;
          $display("FAIL flush_cancel: cancel=%b stall=%b hi=%h lo=%h want 1 0 %h %h",
                   div_cancel, stall_req, hi_out, lo_out, exp_hi, exp_lo);
        end
        tick();
        checks++;
        if (div_cancel !== 1'b0 || div_start !== 1'b0) begin
          errors++; $display("FAIL cancel_width: cancel=%b start=%b want 0 0", div_cancel, div_start);
        end
        return;
      end
      if (k == lat) begin
        div_done = 1'b1;
        div_hi   = r;
        div_lo   = q;
      end
      #1;
      checks++;
      if (stall_req !== 1'b1) begin
        errors++; $display("FAIL busy_stall k=%0d: stall_req=%b want 1", k, stall_req);
      end
      tick();
      div_done = 1'b0;
      div_hi   = $urandom;
      div_lo   = $urandom;
    end
    if (lat == 0) begin
      idle_inputs();
      #1;
      checks++;
      if (div_timeout !== 1'b1 || div_cancel !== 1'b1 || stall_req !== 1'b0 ||
          hi_out !== exp_hi || lo_out !== exp_lo) begin
        errors++;
        $display("FAIL timeout: to=%b cancel=%b stall=%b hi=%h lo=%h want 1 1 0 %h %h",
                 div_timeout, div_cancel, stall_req, hi_out, lo_out, exp_hi, exp_lo);
      end
      tick();
      checks++;
      if (div_cancel !== 1'b0 || div_timeout !== 1'b1) begin
        errors++; $display("FAIL timeout_after: cancel=%b to=%b want 0 1", div_cancel, div_timeout);
      end
      return;
    end
    // WB cycle: DIV retires, result already architectural.
    exp_hi = r;
    exp_lo = q;
    checks++;
    if (stall_req !== 1'b0 || hi_out !== exp_hi || lo_out !== exp_lo || div_start !== 1'b0) begin
      errors++;
      $display("FAIL wb: stall=%b start=%b hi=%h lo=%h want 0 0 %h %h",
               stall_req, div_start, hi_out, lo_out, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hi_out !== '0 || lo_out !== '0 || stall_req !== 1'b0 || div_timeout !== 1'b0 ||
        div_start !== 1'b0 || div_cancel !== 1'b0 || div_op_a !== '0 || div_op_b !== '0 ||
        div_signed !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h stall=%b to=%b start=%b cancel=%b want all 0",
               hi_out, lo_out, stall_req, div_timeout, div_start, div_cancel);
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    tick();
  endtask

  task automatic test_alu_write();
    ex_hilo_we = 2'b11; ex_alu_hi = 32'h1; ex_alu_lo = 32'h2;
    tick();
    checks++;
    if (hi_out !== 32'h1 || lo_out !== 32'h2) begin
      errors++; $display("FAIL alu_mult: hi=%h lo=%h want 1 2", hi_out, lo_out);
    end
    ex_hilo_we = 2'b10; ex_alu_hi = 32'h5; ex_alu_lo = 32'hdead;
    tick();
    checks++;
    if (hi_out !== 32'h5 || lo_out !== 32'h2) begin
      errors++; $display("FAIL alu_mthi: hi=%h lo=%h want 5 2", hi_out, lo_out);
    end
    ex_hilo_we = 2'b01; ex_alu_hi = 32'hbeef; ex_alu_lo = 32'h7;
    tick();
    checks++;
    if (hi_out !== 32'h5 || lo_out !== 32'h7) begin
      errors++; $display("FAIL alu_mtlo: hi=%h lo=%h want 5 7", hi_out, lo_out);
    end
    ex_hilo_we = 2'b11; ex_alu_hi = 32'haaaa; ex_alu_lo = 32'hbbbb; flush = 1'b1;
    tick();
    checks++;
    if (hi_out !== 32'h5 || lo_out !== 32'h7) begin
      errors++; $display("FAIL alu_flush: hi=%h lo=%h want 5 7", hi_out, lo_out);
    end
    idle_inputs();
    div_done = 1'b1; div_hi = 32'h1111; div_lo = 32'h2222;
    tick();
    checks++;
    if (hi_out !== 32'h5 || lo_out !== 32'h7 || stall_req !== 1'b0) begin
      errors++; $display("FAIL idle_done: hi=%h lo=%h stall=%b want 5 7 0", hi_out, lo_out, stall_req);
    end
    idle_inputs();
    exp_hi = 32'h5;
    exp_lo = 32'h7;
  endtask

  task automatic test_div();
    run_div(32'hFFFFFFF9, 32'h2, 1'b1, 33, 0);
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_neg7_2: hi=%h lo=%h want ffffffff fffffffd", hi_out, lo_out);
    end
    idle_inputs();
    #1;
    checks++;
    if (div_start !== 1'b0 || stall_req !== 1'b0) begin
      errors++; $display("FAIL wb_no_relaunch: start=%b stall=%b want 0 0", div_start, stall_req);
    end
    run_div(32'd100, 32'd7, 1'b0, 5, 0);
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    run_div(32'd1000, 32'd3, 1'b0, 10, 10);
    run_div(32'd1000, 32'd3, 1'b0, 20, 4);
  endtask

  task automatic test_timeout();
    run_div(32'h12345678, 32'h9, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_div(32'd77, 32'd5, 1'b0, 3, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 2, 0);
    run_div(32'hFFFFFF00, 32'd16, 1'b1, 1, 0);
    idle_inputs();
    tick();
  endtask

  task automatic test_div_zero();
`ifdef DIV_ZERO_BYPASS_EN
    ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_src_a = 32'h1234; ex_src_b = '0;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL bypass_stall: stall_req=%b want 1", stall_req);
    end
    tick();
    checks++;
    if (div_start !== 1'b0 || stall_req !== 1'b0 || hi_out !== 32'h1234 || lo_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bypass_wb: start=%b stall=%b hi=%h lo=%h want 0 0 1234 ffffffff",
               div_start, stall_req, hi_out, lo_out);
    end
    exp_hi = 32'h1234;
    exp_lo = 32'hFFFFFFFF;
    tick();
`else
    run_div(32'h1234, 32'h0, 1'b1, 6, 0);
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int unsigned  op;
      logic [W-1:0] a, b;
      int unsigned  lat;
      op = $urandom_range(0, 3);
      idle_inputs();
      if (op < 2) begin
        ex_hilo_we = 2'($urandom);
        ex_alu_hi  = $urandom;
        ex_alu_lo  = $urandom;
        if (ex_hilo_we[1]) exp_hi = ex_alu_hi;
        if (ex_hilo_we[0]) exp_lo = ex_alu_lo;
        tick();
        checks++;
        if (hi_out !== exp_hi || lo_out !== exp_lo) begin
          errors++; $display("FAIL rand_alu %0d: hi=%h lo=%h want %h %h", i, hi_out, lo_out, exp_hi, exp_lo);
        end
      end else begin
        a   = $urandom;
        b   = $urandom_range(1, 300);
        if ($urandom_range(0, 1) == 1) b = -b;
        lat = $urandom_range(1, 30);
        run_div(a, b, 1'($urandom), lat, (op == 3) ? $urandom_range(1, lat) : 0);
        checks++;
        if (hi_out !== exp_hi || lo_out !== exp_lo) begin
          errors++; $display("FAIL rand_div %0d: hi=%h lo=%h want %h %h", i, hi_out, lo_out, exp_hi, exp_lo);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    checks++;
    if (div_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: div_timeout=%b want 1", div_timeout);
    end
    ex_div_req = 1'b1; ex_src_a = 32'd50; ex_src_b = 32'd6;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (hi_out !== '0 || lo_out !== '0 || div_start !== 1'b0 || div_cancel !== 1'b0 ||
        div_timeout !== 1'b0 || stall_req !== 1'b0 || div_op_a !== '0) begin
      errors++;
      $display("FAIL async_reset: hi=%h lo=%h start=%b cancel=%b to=%b stall=%b",
               hi_out, lo_out, div_start, div_cancel, div_timeout, stall_req);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checks++;
    if (div_cancel !== 1'b0 || stall_req !== 1'b0 || div_start !== 1'b0) begin
      errors++; $display("FAIL post_reset: cancel=%b stall=%b start=%b want 0 0 0", div_cancel, stall_req, div_start);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_div();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_div_zero();
    test_random();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
